// File: rtl/scope_capture_ctrl_if.sv
// scope_capture_ctrl_if: bundles the capture sequencer's config, control,
// push-port and status signals. Master is the host/scope side; slave is the sequencer.
`default_nettype none

interface scope_capture_ctrl_if #(
  parameter int DEPTH = 64,
  parameter int W     = 6,
  parameter int DIV_W = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]     sample_in;
  logic [DIV_W-1:0] cfg_div;
  logic [1:0]       cfg_trig_mode;
  logic [2:0]       cfg_trig_bit;
  logic             arm;
  logic             abort;
  logic             sink_ready;

  logic             push_valid;
  logic [W-1:0]     push_data;
  logic             busy;
  logic             done;
  logic [1:0]       state;
  logic [CW-1:0]    count;

  modport master (
    output sample_in, cfg_div, cfg_trig_mode, cfg_trig_bit, arm, abort, sink_ready,
    input  push_valid, push_data, busy, done, state, count
  );

  modport slave (
    input  sample_in, cfg_div, cfg_trig_mode, cfg_trig_bit, arm, abort, sink_ready,
    output push_valid, push_data, busy, done, state, count
  );
endinterface

`default_nettype wire

// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl: prescaled, triggered capture of DEPTH samples into a
// local buffer, then an oldest-first drain into the scope push port.
`default_nettype none

module scope_capture_ctrl #(
  parameter int DEPTH = 64,
  parameter int W     = 6,
  parameter int DIV_W = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  scope_capture_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_DRAIN   = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [1:0]       mode_q, mode_d;
  logic [2:0]       tbit_q, tbit_d;
  logic             prev_q, prev_d;
  logic             seen_q, seen_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             done_q, done_d;
  logic [W-1:0]     buf_q [DEPTH];

  logic             tick;
  logic             trig_src;
  logic             trig_hit;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic             push;
  logic [CW-1:0]    count_w;

  assign tick = ((state_q == S_ARMED) || (state_q == S_CAPTURE)) && (presc_q == '0);

  // Out-of-range bit selects fall back to bit 0.
  always_comb begin
    trig_src = bus.sample_in[0];
    for (int i = 0; i < W; i++) begin
      if (int'(tbit_q) == i) trig_src = bus.sample_in[i];
    end
  end

  // Edge modes need one prior tick to establish prev_bit.
  always_comb begin
    case (mode_q)
      2'b00:   trig_hit = 1'b1;
      2'b01:   trig_hit = seen_q && !prev_q && trig_src;
      2'b10:   trig_hit = seen_q && prev_q && !trig_src;
      default: trig_hit = trig_src;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    presc_d  = presc_q;
    mode_d   = mode_q;
    tbit_d   = tbit_q;
    prev_d   = prev_q;
    seen_d   = seen_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = wr_ptr_q;
    push     = 1'b0;

    if ((state_q == S_ARMED) || (state_q == S_CAPTURE)) begin
      presc_d = tick ? div_q : (presc_q - DIV_W'(1));
    end

    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        if (bus.arm) begin
          state_d  = S_ARMED;
          div_d    = bus.cfg_div;
          mode_d   = bus.cfg_trig_mode;
          tbit_d   = bus.cfg_trig_bit;
          presc_d  = bus.cfg_div;
          prev_d   = 1'b0;
          seen_d   = 1'b0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
      end
      S_ARMED: begin
        if (tick) begin
          prev_d = trig_src;
          seen_d = 1'b1;
          if (trig_hit) begin
            wr_en    = 1'b1;
            wr_addr  = '0;
            wr_ptr_d = AW'(1);
            state_d  = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (tick) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (wr_ptr_q == AW'(DEPTH - 1)) begin
            state_d  = S_DRAIN;
            rd_ptr_d = '0;
          end
        end
      end
      default: begin
        push = bus.sink_ready;
        if (push) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          if (rd_ptr_q == AW'(DEPTH - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase

    // abort overrides everything, including a same-cycle arm or final push.
    if (bus.abort) begin
      state_d = S_IDLE;
      presc_d = '0;
      done_d  = 1'b0;
      push    = 1'b0;
      wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      presc_q  <= '0;
      mode_q   <= '0;
      tbit_q   <= '0;
      prev_q   <= 1'b0;
      seen_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      presc_q  <= presc_d;
      mode_q   <= mode_d;
      tbit_q   <= tbit_d;
      prev_q   <= prev_d;
      seen_q   <= seen_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_addr] <= bus.sample_in;
  end

  always_comb begin
    case (state_q)
      S_CAPTURE: count_w = CW'(wr_ptr_q);
      S_DRAIN:   count_w = CW'(DEPTH) - CW'(rd_ptr_q);
      default:   count_w = '0;
    endcase
  end

  assign bus.push_valid = push;
  assign bus.push_data  = push ? buf_q[rd_ptr_q] : '0;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.state      = state_q;
  assign bus.count      = count_w;

endmodule

`default_nettype wire

// File: tb/tb_scope_capture_ctrl.sv
// tb_scope_capture_ctrl: directed scoreboard bench for scope_capture_ctrl;
// expected push values are queued as stimulus is driven and popped on each push.
`default_nettype none

module tb_scope_capture_ctrl;
  localparam int DEPTH = 64;
  localparam int W     = 6;
  localparam int DIV_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scope_capture_ctrl_if #(.DEPTH(DEPTH), .W(W), .DIV_W(DIV_W)) bus ();

  scope_capture_ctrl #(.DEPTH(DEPTH), .W(W), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc_cnt = 0;
  int push_total = 0;
  int done_total = 0;
  int done_cyc = 0;
  int last_push_cyc = 0;
  int drain_pushes = 0;
  logic [W-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [W-1:0] e;
    if (rst_n !== 1'b1) return;
    if (bus.push_valid === 1'b1) begin
      chk("push_needs_ready", bus.sink_ready, 1);
      chk("push_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("push_data", bus.push_data, e);
      end
      chk("drain_count", bus.count, DEPTH - drain_pushes);
      drain_pushes++;
      push_total++;
      last_push_cyc = cyc_cnt;
    end else begin
      chk("push_data_idle", bus.push_data, 0);
    end
    if (bus.done === 1'b1) begin
      done_total++;
      done_cyc = cyc_cnt;
      chk("done_state", bus.state, 0);
      chk("done_busy", bus.busy, 0);
      chk("done_after_last_push", cyc_cnt - last_push_cyc, 1);
      chk("done_push_count", drain_pushes, DEPTH);
    end
    if (bus.state === 2'b00) drain_pushes = 0;
  endtask

  // Samples the current cycle at its falling edge, then steps to just after the next rising edge.
  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc_cnt++;
    #1;
  endtask

  task automatic run_imm(input logic [W-1:0] base, input int arm_at, input int abort_at, input int rst_at);
    int a, pt0, dt0;
    logic fin;
    pt0 = push_total;
    dt0 = done_total;
    bus.arm = 1'b1;
    bus.cfg_div = '0;
    bus.cfg_trig_mode = 2'b00;
    bus.cfg_trig_bit = 3'd0;
    bus.sink_ready = 1'b1;
    bus.sample_in = base;
    a = cyc_cnt;
    cyc();
    // Config changes after acceptance must have no effect.
    bus.cfg_div = 16'd7;
    bus.cfg_trig_mode = 2'b01;
    bus.cfg_trig_bit = 3'd5;
    fin = 1'b0;
    for (int k = 1; k <= 200 && !fin; k++) begin
      bus.arm = (k == arm_at);
      bus.sample_in = base + W'(k);
      if (k <= DEPTH && abort_at == 0) sb.push_back(base + W'(k));
      if (k == 40 && abort_at == 0) chk("capture_count", bus.count, 39);
      if (abort_at > 0 && k == abort_at) begin
        chk("abort_at_count", bus.count, 30);
        bus.abort = 1'b1;
      end
      if (abort_at > 0 && k == abort_at + 1) begin
        bus.abort = 1'b0;
        chk("abort_state", bus.state, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_push_valid", bus.push_valid, 0);
      end
      if (rst_at > 0 && k == rst_at) begin
        chk("rst_at_count", bus.count, 10);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_state", bus.state, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_push_valid", bus.push_valid, 0);
        chk("rst_push_data", bus.push_data, 0);
        chk("rst_count", bus.count, 0);
      end
      if (rst_at > 0 && k == rst_at + 3) rst_n = 1'b1;
      cyc();
      fin = (done_total != dt0);
    end
    bus.arm = 1'b0;
    if (abort_at == 0 && rst_at == 0) begin
      chk("done_seen", done_total - dt0, 1);
      chk("done_cycle", done_cyc - a, 129);
      chk("run_pushes", push_total - pt0, DEPTH);
      chk("sb_left", sb.size(), 0);
      cyc();
      chk("no_rearm_state", bus.state, 0);
    end else begin
      chk("no_done", done_total - dt0, 0);
      chk("run_pushes", push_total - pt0, (rst_at > 0) ? 54 : 0);
      chk("sb_left", sb.size(), (rst_at > 0) ? 10 : 0);
      chk("quiet_state", bus.state, 0);
    end
    sb.delete();
  endtask

  initial begin
    int a, dt0, pt0;
    logic fin;
    logic [W-1:0] v;
    bus.sample_in = '0;
    bus.cfg_div = '0;
    bus.cfg_trig_mode = 2'b00;
    bus.cfg_trig_bit = 3'd0;
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    bus.sink_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", bus.state, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_push_valid", bus.push_valid, 0);
    chk("reset_push_data", bus.push_data, 0);
    chk("reset_count", bus.count, 0);
    rst_n = 1'b1;
    cyc();

    // Immediate trigger at the fastest rate on a ramp.
    run_imm(6'd0, 0, 0, 0);

    // Rising edge on bit 2 with div=3, drained while sink_ready toggles every 5 cycles.
    pt0 = push_total;
    dt0 = done_total;
    bus.arm = 1'b1;
    bus.cfg_div = 16'd3;
    bus.cfg_trig_mode = 2'b01;
    bus.cfg_trig_bit = 3'd2;
    bus.sample_in = '0;
    a = cyc_cnt;
    cyc();
    bus.arm = 1'b0;
    fin = 1'b0;
    for (int k = 1; k <= 700 && !fin; k++) begin
      v = (k >= 20) ? (W'(k * 3) | 6'h04) : 6'h00;
      bus.sample_in = v;
      if (k >= 20 && (k - 20) % 4 == 0 && (k - 20) / 4 < DEPTH) sb.push_back(v);
      bus.sink_ready = ((k / 5) % 2 == 0);
      if (k == 19) chk("edge_still_armed", bus.state, 1);
      if (k == 22) chk("edge_capturing", bus.state, 2);
      cyc();
      fin = (done_total != dt0);
    end
    chk("edge_done_seen", done_total - dt0, 1);
    chk("edge_pushes", push_total - pt0, DEPTH);
    chk("edge_sb_left", sb.size(), 0);
    sb.delete();
    bus.sink_ready = 1'b1;
    cyc();

    // Abort at count=30, then a normal capture, then an arm pulse during DRAIN.
    run_imm(6'd10, 0, 31, 0);
    run_imm(6'd20, 0, 0, 0);
    run_imm(6'd30, 80, 0, 0);

    // arm and abort together while IDLE.
    bus.arm = 1'b1;
    bus.abort = 1'b1;
    cyc();
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    chk("arm_abort_state", bus.state, 0);
    chk("arm_abort_busy", bus.busy, 0);
    cyc();
    chk("arm_abort_state2", bus.state, 0);

    // Asynchronous reset in DRAIN with 10 samples remaining.
    run_imm(6'd40, 0, 0, 119);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
